// File: rtl/conv_vld_gen.sv
`timescale 1ns/1ps
// conv_vld_gen
// Tracks the input pixel raster, flags pixels that complete a KxK window on the
// stride grid, delays that flag by the MAC pipeline depth and qualifies it with
// the per-lane result valids. Produces the registered output valid, output-map
// coordinates, an end-of-frame pulse and a sticky lane/window misalignment flag.
module conv_vld_gen #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int LAT    = 2,
    parameter int N_LANE = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_vld,
    input  logic [N_LANE-1:0] lane_vld,
    output logic              out_vld,
    output logic [CNT_W-1:0]  out_row,
    output logic [CNT_W-1:0]  out_col,
    output logic              frame_done,
    output logic              align_err
);

    localparam int OW = (IMG_W - K) / STRIDE + 1;
    localparam int OH = (IMG_H - K) / STRIDE + 1;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] WIN_START = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] PH_LAST   = CNT_W'(STRIDE - 1);
    localparam logic [CNT_W-1:0] OCOL_LAST = CNT_W'(OW - 1);
    localparam logic [CNT_W-1:0] OROW_LAST = CNT_W'(OH - 1);

    logic [CNT_W-1:0] in_col;
    logic [CNT_W-1:0] in_row;
    logic [CNT_W-1:0] col_ph;
    logic [CNT_W-1:0] row_ph;
    logic [LAT-1:0]   win_pipe;
    logic [LAT-1:0]   win_pipe_nxt;
    logic             col_wrap;
    logic             row_wrap;
    logic             win;
    logic             aligned;
    logic             lane_all;
    logic             fire;
    logic [CNT_W-1:0] adv_col;
    logic [CNT_W-1:0] adv_row;
    logic [CNT_W-1:0] cur_col;
    logic [CNT_W-1:0] cur_row;

    // Window qualifier for the pixel offered this cycle; a clear drops the pixel.
    always_comb begin
        col_wrap = (in_col == COL_LAST);
        row_wrap = (in_row == ROW_LAST);
        win      = in_vld & ~clear
                 & (in_row >= WIN_START) & (in_col >= WIN_START)
                 & (row_ph == '0) & (col_ph == '0);
    end

    // Next contents of the window-valid delay line (works down to a single stage).
    always_comb begin
        win_pipe_nxt    = '0;
        win_pipe_nxt[0] = win;
        for (int i = 1; i < LAT; i++) begin
            win_pipe_nxt[i] = win_pipe[i-1];
        end
    end

    // Output qualification; cur_* is the coordinate the next asserted out_vld will carry.
    always_comb begin
        aligned  = win_pipe[LAT-1];
        lane_all = &lane_vld;
        fire     = aligned & lane_all;
        if (out_col == OCOL_LAST) begin
            adv_col = '0;
            adv_row = (out_row == OROW_LAST) ? '0 : out_row + ONE;
        end else begin
            adv_col = out_col + ONE;
            adv_row = out_row;
        end
        cur_col = out_vld ? adv_col : out_col;
        cur_row = out_vld ? adv_row : out_row;
    end

    // Raster and stride-phase counters; phases restart at the window edge instead of using modulo.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_col <= '0;
            in_row <= '0;
            col_ph <= '0;
            row_ph <= '0;
        end else if (clear) begin
            in_col <= '0;
            in_row <= '0;
            col_ph <= '0;
            row_ph <= '0;
        end else if (in_vld) begin
            in_col <= col_wrap ? '0 : in_col + ONE;
            if (col_wrap || (in_col < WIN_START)) begin
                col_ph <= '0;
            end else begin
                col_ph <= (col_ph == PH_LAST) ? '0 : col_ph + ONE;
            end
            if (col_wrap) begin
                in_row <= row_wrap ? '0 : in_row + ONE;
                if (row_wrap || (in_row < WIN_START)) begin
                    row_ph <= '0;
                end else begin
                    row_ph <= (row_ph == PH_LAST) ? '0 : row_ph + ONE;
                end
            end
        end
    end

    // Window-valid delay line, shifted every cycle so bubbles travel as zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_pipe <= '0;
        end else if (clear) begin
            win_pipe <= '0;
        end else begin
            win_pipe <= win_pipe_nxt;
        end
    end

    // Registered output valid, coordinates and end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld    <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
        end else if (clear) begin
            out_vld    <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            out_vld    <= fire;
            out_row    <= cur_row;
            out_col    <= cur_col;
            frame_done <= fire & (cur_row == OROW_LAST) & (cur_col == OCOL_LAST);
        end
    end

    // Sticky flag: lanes disagree with the aligned window valid (partial lanes count too).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_err <= 1'b0;
        end else if (clear) begin
            align_err <= 1'b0;
        end else if (aligned != lane_all) begin
            align_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_vld_gen.sv
`timescale 1ns/1ps
// Bench for conv_vld_gen: three instances (4x4 K3 S1 LAT2, 5x5 K3 S2 LAT1,
// 3x5 K3 S2 LAT3 with a single output column), a pixel-index model and
// literal per-scenario expectations.
module tb_conv_vld_gen;

    localparam int NI = 3;
    localparam int NL = 4;
    localparam int CW = 8;
    localparam int PW [NI] = '{4, 5, 3};
    localparam int PH [NI] = '{4, 5, 5};
    localparam int PK [NI] = '{3, 3, 3};
    localparam int PS [NI] = '{1, 2, 2};
    localparam int PL [NI] = '{2, 1, 3};
    localparam int HIST = 4096;

    typedef struct {
        int inst;
        int c;
        int row;
        int col;
        bit fd;
    } ev_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic [NI-1:0] in_vld = '0;
    logic [NL-1:0] lane [NI] = '{default: '0};
    logic          o_vld [NI];
    logic [CW-1:0] o_row [NI];
    logic [CW-1:0] o_col [NI];
    logic          o_fd  [NI];
    logic          o_err [NI];

    int  cyc = 0;
    int  nchk = 0;
    int  nbad = 0;
    bit  force_en = 1'b0;
    logic [NL-1:0] force_val = 4'b1011;

    int  pix [NI];
    int  oidx [NI];
    int  vf [NI];
    bit  merr [NI];
    bit  mvld [NI];
    bit  mfd [NI];
    int  mrow [NI];
    int  mcol [NI];
    bit  win_at [NI][HIST];

    ev_t evq [$];
    ev_t selq [$];

    always #5 clk = ~clk;

    conv_vld_gen #(.IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1), .LAT(2), .N_LANE(NL), .CNT_W(CW)) u_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_vld(in_vld[0]), .lane_vld(lane[0]),
        .out_vld(o_vld[0]), .out_row(o_row[0]), .out_col(o_col[0]), .frame_done(o_fd[0]), .align_err(o_err[0]));
    conv_vld_gen #(.IMG_W(5), .IMG_H(5), .K(3), .STRIDE(2), .LAT(1), .N_LANE(NL), .CNT_W(CW)) u_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_vld(in_vld[1]), .lane_vld(lane[1]),
        .out_vld(o_vld[1]), .out_row(o_row[1]), .out_col(o_col[1]), .frame_done(o_fd[1]), .align_err(o_err[1]));
    conv_vld_gen #(.IMG_W(3), .IMG_H(5), .K(3), .STRIDE(2), .LAT(3), .N_LANE(NL), .CNT_W(CW)) u_c (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_vld(in_vld[2]), .lane_vld(lane[2]),
        .out_vld(o_vld[2]), .out_row(o_row[2]), .out_col(o_col[2]), .frame_done(o_fd[2]), .align_err(o_err[2]));

    // Window test from the pixel's position in the frame.
    function automatic bit is_win(input int i, input int p);
        int r;
        int c;
        r = p / PW[i];
        c = p % PW[i];
        return (r >= PK[i] - 1) && (c >= PK[i] - 1)
            && ((r - PK[i] + 1) % PS[i] == 0) && ((c - PK[i] + 1) % PS[i] == 0);
    endfunction

    // True when the window pixel accepted LAT edges ago lines up with edge n.
    function automatic bit aligned(input int i, input int n);
        int m;
        m = n - PL[i];
        if (m < 0 || m < vf[i] || m >= HIST) return 1'b0;
        return win_at[i][m];
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input int exp);
        nchk++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model: expected register contents after edge number cyc.
    always @(posedge clk) begin : model
        bit al;
        bit la;
        int ow;
        int oh;
        int idx;
        for (int i = 0; i < NI; i++) begin
            if (!rst_n || clear) begin
                pix[i]  = 0;
                oidx[i] = 0;
                merr[i] = 1'b0;
                mvld[i] = 1'b0;
                mfd[i]  = 1'b0;
                vf[i]   = cyc + 1;
                win_at[i][cyc % HIST] = 1'b0;
            end else begin
                al = aligned(i, cyc);
                la = &lane[i];
                if (al != la) merr[i] = 1'b1;
                mvld[i] = al && la;
                mfd[i]  = 1'b0;
                if (mvld[i]) begin
                    ow = (PW[i] - PK[i]) / PS[i] + 1;
                    oh = (PH[i] - PK[i]) / PS[i] + 1;
                    idx = oidx[i] % (ow * oh);
                    mrow[i] = idx / ow;
                    mcol[i] = idx % ow;
                    mfd[i]  = (idx == ow * oh - 1);
                    oidx[i]++;
                end
                win_at[i][cyc % HIST] = in_vld[i] && is_win(i, pix[i]);
                if (in_vld[i]) pix[i] = (pix[i] + 1) % (PW[i] * PH[i]);
            end
        end
    end

    // Lanes report a result exactly when a window is due, unless forced to a partial pattern.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!aligned(i, cyc)) lane[i] = '0;
            else if (force_en && i == 0) lane[i] = force_val;
            else lane[i] = '1;
        end
    end

    // Per-cycle compare against the model, plus an event log for literal checks.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("out_vld[%0d]", i), {31'b0, o_vld[i]}, int'(mvld[i]));
            chk($sformatf("frame_done[%0d]", i), {31'b0, o_fd[i]}, int'(mfd[i]));
            chk($sformatf("align_err[%0d]", i), {31'b0, o_err[i]}, int'(merr[i]));
            if (mvld[i]) begin
                chk($sformatf("out_row[%0d]", i), {24'b0, o_row[i]}, mrow[i]);
                chk($sformatf("out_col[%0d]", i), {24'b0, o_col[i]}, mcol[i]);
            end
            if (o_vld[i] === 1'b1) evq.push_back('{i, cyc, int'(o_row[i]), int'(o_col[i]), o_fd[i]});
        end
    end

    task automatic step(input logic [NI-1:0] iv, input logic clr);
        @(negedge clk);
        in_vld = iv;
        clear  = clr;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, 1'b0);
    endtask

    task automatic feed(input int inst, input int n);
        for (int k = 0; k < n; k++) step(NI'(1 << inst), 1'b0);
    endtask

    task automatic select(input int inst, input int c0);
        selq.delete();
        foreach (evq[k]) if (evq[k].inst == inst && evq[k].c > c0) selq.push_back(evq[k]);
    endtask

    task automatic check_frame(input string nm, input int inst, input int c0,
                               input int rows[4], input int cols[4], input int fds[4]);
        select(inst, c0);
        chk({nm, "_count"}, selq.size(), 4);
        for (int k = 0; k < 4 && k < selq.size(); k++) begin
            chk($sformatf("%s_row%0d", nm, k), selq[k].row, rows[k]);
            chk($sformatf("%s_col%0d", nm, k), selq[k].col, cols[k]);
            chk($sformatf("%s_fd%0d", nm, k), {31'b0, selq[k].fd}, fds[k]);
        end
    endtask

    initial begin : stim
        int c0;
        int t10;
        int acc;
        bit b;
        bit found;

        idle(3);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_vld%0d", i), {31'b0, o_vld[i]}, 0);
            chk($sformatf("rst_fd%0d", i), {31'b0, o_fd[i]}, 0);
            chk($sformatf("rst_err%0d", i), {31'b0, o_err[i]}, 0);
            chk($sformatf("rst_row%0d", i), {24'b0, o_row[i]}, 0);
            chk($sformatf("rst_col%0d", i), {24'b0, o_col[i]}, 0);
        end
        rst_n = 1'b1;
        idle(2);

        // 4x4 frame, back to back
        c0 = cyc;
        t10 = -100;
        for (int p = 0; p < 16; p++) begin
            step(3'b001, 1'b0);
            if (p == 10) t10 = cyc;
        end
        idle(6);
        select(0, c0);
        chk("a1_first_latency", (selq.size() > 0) ? selq[0].c - t10 : -1, 3);
        check_frame("a1", 0, c0, '{0, 0, 1, 1}, '{0, 1, 0, 1}, '{0, 0, 0, 1});
        chk("a1_err", {31'b0, o_err[0]}, 0);

        // 5x5 stride 2 with bubbles
        c0 = cyc;
        acc = 0;
        for (int s = 0; s < 200 && acc < 25; s++) begin
            b = 1'($urandom_range(0, 1));
            step({1'b0, b, 1'b0}, 1'b0);
            acc += int'(b);
        end
        chk("b_fed", acc, 25);
        idle(5);
        check_frame("b", 1, c0, '{0, 0, 1, 1}, '{0, 1, 0, 1}, '{0, 0, 0, 1});

        // two 4x4 frames with no gap: second frame repeats the first 16 cycles later
        c0 = cyc;
        feed(0, 32);
        idle(6);
        select(0, c0);
        chk("a2_count", selq.size(), 8);
        for (int k = 0; k < 4 && k + 4 < selq.size(); k++) begin
            chk($sformatf("a2_period%0d", k), selq[k+4].c - selq[k].c, 16);
            chk($sformatf("a2_fd%0d", k), {31'b0, selq[k+4].fd}, (k == 3) ? 1 : 0);
        end

        // single output column, two frames back to back
        c0 = cyc;
        feed(2, 30);
        idle(6);
        check_frame("c", 2, c0, '{0, 1, 0, 1}, '{0, 0, 0, 0}, '{0, 1, 0, 1});

        // partial lanes on aligned cycles
        force_en = 1'b1;
        c0 = cyc;
        feed(0, 16);
        idle(5);
        select(0, c0);
        chk("force_no_vld", selq.size(), 0);
        chk("force_err_set", {31'b0, o_err[0]}, 1);
        force_en = 1'b0;
        c0 = cyc;
        feed(0, 16);
        idle(6);
        chk("force_err_hold", {31'b0, o_err[0]}, 1);
        check_frame("post_force", 0, c0, '{0, 0, 1, 1}, '{0, 1, 0, 1}, '{0, 0, 0, 1});
        step('0, 1'b1);
        step('0, 1'b0);
        chk("force_err_cleared", {31'b0, o_err[0]}, 0);

        // clear mid-frame together with a pixel
        c0 = cyc;
        feed(0, 7);
        step(3'b001, 1'b1);
        feed(0, 16);
        idle(6);
        check_frame("midclr", 0, c0, '{0, 0, 1, 1}, '{0, 1, 0, 1}, '{0, 0, 0, 1});

        // async reset while out_vld and frame_done are high
        found = 1'b0;
        for (int s = 0; s < 60; s++) begin
            step(3'b001, 1'b0);
            if (o_fd[0] === 1'b1 && o_vld[0] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("async_found_fd", {31'b0, found}, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_vld", {31'b0, o_vld[0]}, 0);
        chk("async_fd", {31'b0, o_fd[0]}, 0);
        chk("async_err", {31'b0, o_err[0]}, 0);
        step('0, 1'b0);
        step('0, 1'b0);
        rst_n = 1'b1;
        c0 = cyc;
        feed(0, 16);
        idle(6);
        check_frame("post_rst", 0, c0, '{0, 0, 1, 1}, '{0, 1, 0, 1}, '{0, 0, 0, 1});

        idle(2);
        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
